// File: rtl/tlb_ctrl.sv
// tlb_ctrl: sequences TLBP/TLBR/TLBWI/TLBWR against an external TLB and maintains the Random register
module tlb_ctrl #(
  parameter int TLBNUM = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  input  logic [26:0] cp0_entryhi,
  input  logic [25:0] cp0_entrylo0,
  input  logic [25:0] cp0_entrylo1,
  input  logic [15:0] cp0_pagemask,
  input  logic [2:0]  cp0_index,
  input  logic [2:0]  cp0_wired,
  output logic [18:0] tlb_s_vpn2,
  output logic [7:0]  tlb_s_asid,
  input  logic        tlb_s_found,
  input  logic [2:0]  tlb_s_index,
  output logic        tlb_we,
  output logic [2:0]  tlb_w_index,
  output logic [93:0] tlb_w_entry,
  output logic [2:0]  tlb_r_index,
  input  logic [93:0] tlb_r_entry,
  output logic        done_valid,
  output logic [1:0]  done_op,
  output logic        p_miss,
  output logic [2:0]  p_index,
  output logic [26:0] rd_entryhi,
  output logic [25:0] rd_entrylo0,
  output logic [25:0] rd_entrylo1,
  output logic [15:0] rd_pagemask,
  output logic [2:0]  random
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam logic [1:0] OP_P = 2'b00, OP_R = 2'b01, OP_WR = 2'b11;
  localparam logic [2:0] TOP = 3'(TLBNUM - 1);
  state_t      r_state, w_next;
  logic [1:0]  r_op;
  logic [26:0] r_hi;
  logic [25:0] r_lo0, r_lo1;
  logic [15:0] r_mask;
  logic [2:0]  r_idx, r_random;
  logic        w_accept;
  assign w_accept    = cmd_valid && cmd_ready;
  assign tlb_s_vpn2  = r_hi[26:8];
  assign tlb_s_asid  = r_hi[7:0];
  assign tlb_w_index = r_idx;
  assign tlb_r_index = r_idx;
  assign tlb_w_entry = {r_hi, r_lo0[0] & r_lo1[0], r_lo0[25:1], r_lo1[25:1], r_mask};
  assign done_op     = r_op;
  assign random      = r_random;
  // state register
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  // next state and strobes; reset masks strobes so an aborted command has no visible effect
  always_comb begin
    w_next     = (r_state == IDLE) ? (cmd_valid ? EXEC : IDLE) : (r_state == EXEC) ? DONE : IDLE;
    cmd_ready  = r_state == IDLE;
    tlb_we     = r_state == EXEC && r_op[1] && !reset;
    done_valid = r_state == DONE && !reset;
  end
  // capture command and CP0 operands at acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op   <= '0;
      r_hi   <= '0;
      r_lo0  <= '0;
      r_lo1  <= '0;
      r_mask <= '0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_op   <= cmd_op;
      r_hi   <= cp0_entryhi;
      r_lo0  <= cp0_entrylo0;
      r_lo1  <= cp0_entrylo1;
      r_mask <= cp0_pagemask;
      r_idx  <= (cmd_op == OP_WR) ? r_random : cp0_index;
    end
  end
  // probe and read results, held until the next command of the same kind
  always_ff @(posedge clk) begin
    if (reset) begin
      p_miss      <= 1'b0;
      p_index     <= '0;
      rd_entryhi  <= '0;
      rd_entrylo0 <= '0;
      rd_entrylo1 <= '0;
      rd_pagemask <= '0;
    end else if (r_state == EXEC) begin
      if (r_op == OP_P) begin
        p_miss  <= ~tlb_s_found;
        p_index <= tlb_s_found ? tlb_s_index : 3'd0;
      end
      if (r_op == OP_R) begin
        rd_entryhi  <= tlb_r_entry[93:67];
        rd_entrylo0 <= {tlb_r_entry[65:41], tlb_r_entry[66]};
        rd_entrylo1 <= {tlb_r_entry[40:16], tlb_r_entry[66]};
        rd_pagemask <= tlb_r_entry[15:0];
      end
    end
  end
  // Random counts down and wraps to the top once it reaches the wired boundary
  always_ff @(posedge clk) r_random <= (reset || r_random <= cp0_wired) ? TOP : r_random - 3'd1;
endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl: directed checks of tlb_ctrl against a small behavioural TLB
module tb_tlb_ctrl;
  logic        clk = 0, reset = 1, cmd_valid = 0;
  logic [1:0]  cmd_op = 0;
  logic        cmd_ready;
  logic [26:0] cp0_entryhi = 0;
  logic [25:0] cp0_entrylo0 = 0, cp0_entrylo1 = 0;
  logic [15:0] cp0_pagemask = 0;
  logic [2:0]  cp0_index = 0, cp0_wired = 0;
  logic [18:0] tlb_s_vpn2;
  logic [7:0]  tlb_s_asid;
  logic        tlb_s_found;
  logic [2:0]  tlb_s_index;
  logic        tlb_we;
  logic [2:0]  tlb_w_index, tlb_r_index;
  logic [93:0] tlb_w_entry, tlb_r_entry;
  logic        done_valid;
  logic [1:0]  done_op;
  logic        p_miss;
  logic [2:0]  p_index, random;
  logic [26:0] rd_entryhi;
  logic [25:0] rd_entrylo0, rd_entrylo1;
  logic [15:0] rd_pagemask;
  logic [93:0] tlb_m [8];
  int total = 0, bad = 0;

  tlb_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .cp0_pagemask(cp0_pagemask), .cp0_index(cp0_index), .cp0_wired(cp0_wired),
    .tlb_s_vpn2(tlb_s_vpn2), .tlb_s_asid(tlb_s_asid), .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
    .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
    .done_valid(done_valid), .done_op(done_op), .p_miss(p_miss), .p_index(p_index),
    .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0), .rd_entrylo1(rd_entrylo1),
    .rd_pagemask(rd_pagemask), .random(random)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 8; i++) tlb_m[i] = '0;
  always @(posedge clk) if (tlb_we) tlb_m[tlb_w_index] <= tlb_w_entry;
  assign tlb_r_entry = tlb_m[tlb_r_index];
  always_comb begin
    tlb_s_found = 1'b0;
    tlb_s_index = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (tlb_m[i][93:75] == tlb_s_vpn2 && (tlb_m[i][66] || tlb_m[i][74:67] == tlb_s_asid)) begin
        tlb_s_found = 1'b1;
        tlb_s_index = 3'(i);
      end
  end

  localparam logic [26:0] HI   = {19'h1234, 8'h05};
  localparam logic [25:0] LO0  = {20'hABCDE, 3'd3, 3'b111};
  localparam logic [25:0] LO1  = {20'h12345, 3'd2, 3'b010};
  localparam logic [15:0] MASK = 16'h00FF;
  localparam logic [93:0] WENT = {19'h1234, 8'h05, 1'b0, 20'hABCDE, 3'd3, 2'b11, 20'h12345, 3'd2, 2'b01, 16'h00FF};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op);
    cmd_valid = 1;
    cmd_op = op;
    tick;
    cmd_valid = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    tick;
    tick;
    reset = 0;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", cmd_ready); end
    total++; if (tlb_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", tlb_we); end
    total++; if (done_valid !== 1'b0 || done_op !== 2'd0) begin bad++; $display("FAIL rst_done got=%0b/%0d exp=0/0", done_valid, done_op); end
    total++; if (p_miss !== 1'b0 || p_index !== 3'd0) begin bad++; $display("FAIL rst_p got=%0b/%0d exp=0/0", p_miss, p_index); end
    total++; if ({rd_entryhi, rd_entrylo0, rd_entrylo1, rd_pagemask} !== '0) begin bad++; $display("FAIL rst_rd got=%h exp=0", rd_entryhi); end
    total++; if (random !== 3'd7) begin bad++; $display("FAIL rst_random got=%0d exp=7", random); end
  endtask

  task automatic test_tlbwi;
    cp0_entryhi = HI; cp0_entrylo0 = LO0; cp0_entrylo1 = LO1; cp0_pagemask = MASK; cp0_index = 3;
    issue(2'b10);
    cp0_entryhi = '1; cp0_entrylo0 = '1; cp0_entrylo1 = '1; cp0_pagemask = '1; cp0_index = 0;
    #1;
    total++; if (tlb_we !== 1'b1) begin bad++; $display("FAIL wi_we_t1 got=%0b exp=1", tlb_we); end
    total++; if (tlb_w_index !== 3'd3) begin bad++; $display("FAIL wi_index got=%0d exp=3", tlb_w_index); end
    total++; if (tlb_w_entry !== WENT) begin bad++; $display("FAIL wi_entry got=%h exp=%h", tlb_w_entry, WENT); end
    total++; if (cmd_ready !== 1'b0 || done_valid !== 1'b0) begin bad++; $display("FAIL wi_exec got=%0b/%0b exp=0/0", cmd_ready, done_valid); end
    tick;
    total++; if (tlb_we !== 1'b0) begin bad++; $display("FAIL wi_we_t2 got=%0b exp=0", tlb_we); end
    total++; if (done_valid !== 1'b1 || done_op !== 2'b10) begin bad++; $display("FAIL wi_done got=%0b/%0d exp=1/2", done_valid, done_op); end
    tick;
    total++; if (done_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL wi_idle got=%0b/%0b exp=0/1", done_valid, cmd_ready); end
  endtask

  task automatic test_tlbp;
    cp0_entryhi = HI;
    issue(2'b00);
    tick;
    total++; if (done_valid !== 1'b1 || done_op !== 2'b00) begin bad++; $display("FAIL p_done got=%0b/%0d exp=1/0", done_valid, done_op); end
    total++; if (p_miss !== 1'b0 || p_index !== 3'd3) begin bad++; $display("FAIL p_hit got=%0b/%0d exp=0/3", p_miss, p_index); end
    tick;
    cp0_entryhi = {19'h1234, 8'h06};
    issue(2'b00);
    tick;
    total++; if (p_miss !== 1'b1 || p_index !== 3'd0) begin bad++; $display("FAIL p_miss got=%0b/%0d exp=1/0", p_miss, p_index); end
    tick;
  endtask

  task automatic test_tlbr;
    cp0_index = 3;
    cp0_entryhi = 0;
    issue(2'b01);
    tick;
    total++; if (done_valid !== 1'b1 || done_op !== 2'b01) begin bad++; $display("FAIL r_done got=%0b/%0d exp=1/1", done_valid, done_op); end
    total++; if (rd_entryhi !== HI) begin bad++; $display("FAIL r_hi got=%h exp=%h", rd_entryhi, HI); end
    total++; if (rd_entrylo0 !== {20'hABCDE, 3'd3, 3'b110}) begin bad++; $display("FAIL r_lo0 got=%h exp=%h", rd_entrylo0, {20'hABCDE, 3'd3, 3'b110}); end
    total++; if (rd_entrylo1 !== LO1) begin bad++; $display("FAIL r_lo1 got=%h exp=%h", rd_entrylo1, LO1); end
    total++; if (rd_pagemask !== MASK) begin bad++; $display("FAIL r_mask got=%h exp=%h", rd_pagemask, MASK); end
    total++; if (p_miss !== 1'b1) begin bad++; $display("FAIL r_p_hold got=%0b exp=1", p_miss); end
    tick;
  endtask

  task automatic test_random;
    int seq [10] = '{7, 6, 5, 4, 3, 2, 7, 6, 5, 4};
    cp0_wired = 2;
    reset = 1;
    tick;
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      total++; if (random !== 3'(seq[i])) begin bad++; $display("FAIL rand_seq%0d got=%0d exp=%0d", i, random, seq[i]); end
      if (i < 9) tick;
    end
    cp0_entryhi = HI; cp0_entrylo0 = LO0; cp0_entrylo1 = LO1; cp0_pagemask = MASK; cp0_index = 1;
    issue(2'b11);
    total++; if (tlb_we !== 1'b1 || tlb_w_index !== 3'd4) begin bad++; $display("FAIL wr_index got=%0b/%0d exp=1/4", tlb_we, tlb_w_index); end
    tick;
    tick;
    cp0_wired = 7;
    tick;
    tick;
    for (int i = 0; i < 3; i++) begin
      total++; if (random !== 3'd7) begin bad++; $display("FAIL rand_wired7 got=%0d exp=7", random); end
      tick;
    end
    cp0_wired = 0;
  endtask

  task automatic test_back_to_back;
    cmd_valid = 1;
    cmd_op = 2'b00;
    for (int i = 0; i < 9; i++) begin
      total++; if (cmd_ready !== (i % 3 == 0)) begin bad++; $display("FAIL b2b_ready%0d got=%0b exp=%0b", i, cmd_ready, i % 3 == 0); end
      total++; if (done_valid !== (i % 3 == 2)) begin bad++; $display("FAIL b2b_done%0d got=%0b exp=%0b", i, done_valid, i % 3 == 2); end
      tick;
    end
    cmd_valid = 0;
    tick;
  endtask

  task automatic test_reset_abort;
    cp0_index = 5;
    cp0_entryhi = {19'h7777, 8'h11};
    issue(2'b10);
    reset = 1;
    #1;
    total++; if (tlb_we !== 1'b0) begin bad++; $display("FAIL abort_we got=%0b exp=0", tlb_we); end
    tick;
    reset = 0;
    total++; if (cmd_ready !== 1'b1 || done_valid !== 1'b0) begin bad++; $display("FAIL abort_state got=%0b/%0b exp=1/0", cmd_ready, done_valid); end
    tick;
    total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL abort_done got=%0b exp=0", done_valid); end
    total++; if (tlb_m[5] !== '0) begin bad++; $display("FAIL abort_write got=%h exp=0", tlb_m[5]); end
    total++; if (rd_entryhi !== '0) begin bad++; $display("FAIL abort_rd got=%h exp=0", rd_entryhi); end
  endtask

  initial begin
    test_reset;
    test_tlbwi;
    test_tlbp;
    test_tlbr;
    test_random;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tlb_ctrl.md
TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 8, number of TLB entries; index width 3.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  TLB instruction request.
REQ-005 SHALL have port cmd_op  input  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR.
REQ-006 SHALL have port cmd_ready  output  1  controller idle and able to accept.
REQ-007 SHALL have port cp0_entryhi  input  27  {vpn2[18:0], asid[7:0]}.
REQ-008 SHALL have ports cp0_entrylo0 / cp0_entrylo1  input  26 each  {pfn[19:0], c[2:0], d, v, g}.
REQ-009 SHALL have ports cp0_pagemask  input  16 and cp0_index / cp0_wired  input  3 each.
REQ-010 SHALL have ports tlb_s_vpn2  output  19, tlb_s_asid  output  8, tlb_s_found  input  1, tlb_s_index  input  3: TLB search port.
REQ-011 SHALL have ports tlb_we  output  1, tlb_w_index  output  3, tlb_w_entry  output  94: write port.
REQ-012 SHALL have ports tlb_r_index  output  3, tlb_r_entry  input  94: read port.
REQ-013 94-bit entry packing SHALL be {vpn2 19, asid 8, g, pfn0 20, c0 3, d0, v0, pfn1 20, c1 3, d1, v1, mask 16}, MSB first.
REQ-014 SHALL have port done_valid  output  1  one-cycle completion pulse, and done_op  output  2.
REQ-015 SHALL have ports p_miss  output  1 and p_index  output  3: TLBP result.
REQ-016 SHALL have ports rd_entryhi  output  27, rd_entrylo0 / rd_entrylo1  output  26, rd_pagemask  output  16: TLBR result.
REQ-017 SHALL have port random  output  3: current Random register.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, DONE; cmd_ready = (state==IDLE).
REQ-019 Accept on cmd_valid && cmd_ready (cycle T); op, entryhi, entrylo0/1, pagemask, target index latched at T; CP0 changes after T have no effect.
REQ-020 Target index: TLBWI -> cp0_index, TLBWR -> random value at T, TLBR -> cp0_index.
REQ-021 EXEC (T+1): TLBP drives latched vpn2/asid on search port and registers tlb_s_found/tlb_s_index; TLBR drives tlb_r_index and registers tlb_r_entry; TLBWI/TLBWR assert tlb_we for exactly this one cycle.
REQ-022 Write entry: g = lo0.g & lo1.g; all other fields copied from latched registers unmodified.
REQ-023 DONE (T+2): done_valid=1 for one cycle, done_op=latched op; next state IDLE; next accept no earlier than T+3.
REQ-024 TLBP: p_miss = ~found, p_index = found ? tlb_s_index : 0; entry valid bits ignored for match.
REQ-025 TLBR: rd_entryhi={vpn2,asid}, rd_entrylo0={pfn0,c0,d0,v0,g}, rd_entrylo1={pfn1,c1,d1,v1,g}, rd_pagemask=mask.
REQ-026 Result outputs SHALL hold until overwritten by the next command of the same class.
REQ-027 Random SHALL decrement every cycle; when random == cp0_wired it loads 7 next cycle; if random < cp0_wired it loads 7; cp0_wired = 7 holds random at 7.
REQ-028 cmd_valid while busy SHALL be ignored (no queueing); tlb_we SHALL be 0 in all states except EXEC for a write op.

Reset
REQ-029 On reset: state IDLE, cmd_ready 1, tlb_we 0, done_valid 0, done_op 0, p_miss 0, p_index 0, rd_* 0, random 7, latches 0.
REQ-030 Reset in EXEC or DONE SHALL abort with no write issued and no done_valid pulse.

Verification
REQ-031 TLBWI, cp0_index=3, entryhi={19'h1234,8'h05}, lo0.g=1, lo1.g=0 -> tlb_we at T+1 only, w_index=3, w_entry.g=0, done_valid at T+2.
REQ-032 TLBP after REQ-031 write with matching vpn2/asid -> p_miss=0, p_index=3; asid 8'h06 -> p_miss=1, p_index=0.
REQ-033 TLBR index 3 -> rd_entryhi={19'h1234,8'h05}, both rd_entrylo g bits=0, rd_pagemask=stored mask.
REQ-034 cp0_wired=2, free-running -> random sequence 7,6,5,4,3,2,7,...; TLBWR writes to random value sampled at T.
REQ-035 cmd_valid held high continuously -> accepts every third cycle; reset asserted at T+1 of TLBWI -> tlb_we 0, no done_valid, cmd_ready 1 next cycle.
